// File: rtl/acorn128_input_loader.sv
// acorn128_input_loader: gathers one ACORN-128 job (key, IV, AD, text, length)
// from a 32-bit valid/ready word stream, pulses start to the core and waits for
// the core's ready rising edge, giving up after WAIT_TIMEOUT cycles.
// Optional feature: define ACORN_KEY_RETAIN_EN to let a job reuse the stored key.
module acorn128_input_loader #(
   parameter int unsigned WAIT_TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_first,
   input  logic         s_encrypt,
   input  logic         s_keep_key,
   output logic [127:0] key_o,
   output logic [127:0] iv_o,
   output logic [127:0] ad_o,
   output logic [127:0] text_o,
   output logic [63:0]  length_o,
   output logic         encrypt_o,
   output logic         start_o,
   input  logic         core_ready_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY, S_IV, S_AD, S_TEXT, S_LEN, S_START, S_WAIT
   } state_t;

   localparam logic [31:0] TMO_LAST = WAIT_TIMEOUT - 32'd1;
   localparam bit          TMO_EN   = (WAIT_TIMEOUT != 0);

   state_t         state_q;
   logic [1:0]     cnt_q;
   logic [31:0]    timer_q;
   logic           rdy_q;
   logic [127:0]   key_q;
   logic [127:0]   iv_q;
   logic [127:0]   ad_q;
   logic [127:0]   text_q;
   logic [63:0]    length_q;
   logic           encrypt_q;
   logic           start_q;
   logic           s_ready_q;
   logic           busy_q;
   logic           done_q;
   logic           err_q;
   logic           xfer;
   logic           skip_key;

   assign xfer = s_valid & s_ready_q;

`ifdef ACORN_KEY_RETAIN_EN
   logic key_valid_q;
   assign skip_key = s_keep_key & key_valid_q;
`else
   logic unused_keep;
   assign unused_keep = s_keep_key;
   assign skip_key    = 1'b0;
`endif

   // Job collection, start pulse and core-ready wait, all outputs registered
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         timer_q   <= '0;
         rdy_q     <= 1'b0;
         key_q     <= '0;
         iv_q      <= '0;
         ad_q      <= '0;
         text_q    <= '0;
         length_q  <= '0;
         encrypt_q <= 1'b0;
         start_q   <= 1'b0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef ACORN_KEY_RETAIN_EN
         key_valid_q <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE, S_KEY, S_IV, S_AD, S_TEXT, S_LEN: begin
               s_ready_q <= 1'b1;
               if (xfer) begin
                  if (s_first) begin
                     // A first word always (re)starts a job; mid-job it is also a framing error.
                     err_q     <= (state_q != S_IDLE);
                     busy_q    <= 1'b1;
                     encrypt_q <= s_encrypt;
                     cnt_q     <= 2'd1;
                     if (skip_key) begin
                        iv_q[127:96] <= s_data;
                        state_q      <= S_IV;
                     end else begin
                        key_q[127:96] <= s_data;
                        state_q       <= S_KEY;
`ifdef ACORN_KEY_RETAIN_EN
                        // The stored key is being overwritten, so it is no longer reusable
                        // until this job completes.
                        key_valid_q <= 1'b0;
`endif
                     end
                  end else if (state_q == S_IDLE) begin
                     err_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 2'd1;
                     case (state_q)
                        S_KEY: begin
                           key_q[{~cnt_q, 5'd0} +: 32] <= s_data;
                           if (cnt_q == 2'd3) state_q <= S_IV;
                        end
                        S_IV: begin
                           iv_q[{~cnt_q, 5'd0} +: 32] <= s_data;
                           if (cnt_q == 2'd3) state_q <= S_AD;
                        end
                        S_AD: begin
                           ad_q[{~cnt_q, 5'd0} +: 32] <= s_data;
                           if (cnt_q == 2'd3) state_q <= S_TEXT;
                        end
                        S_TEXT: begin
                           text_q[{~cnt_q, 5'd0} +: 32] <= s_data;
                           if (cnt_q == 2'd3) state_q <= S_LEN;
                        end
                        S_LEN: begin
                           length_q[{~cnt_q[0], 5'd0} +: 32] <= s_data;
                           if (cnt_q[0]) begin
                              state_q   <= S_START;
                              cnt_q     <= '0;
                              start_q   <= 1'b1;
                              s_ready_q <= 1'b0;
`ifdef ACORN_KEY_RETAIN_EN
                              key_valid_q <= 1'b1;
`endif
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_START: begin
               // Capture ready here so a level already high on entry is not taken as an edge.
               rdy_q   <= core_ready_i;
               timer_q <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               rdy_q   <= core_ready_i;
               timer_q <= timer_q + 32'd1;
               if (core_ready_i && !rdy_q) begin
                  done_q    <= 1'b1;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  s_ready_q <= 1'b1;
               end else if (TMO_EN && (timer_q == TMO_LAST)) begin
                  err_q     <= 1'b1;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  s_ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign s_ready   = s_ready_q;
   assign key_o     = key_q;
   assign iv_o      = iv_q;
   assign ad_o      = ad_q;
   assign text_o    = text_q;
   assign length_o  = length_q;
   assign encrypt_o = encrypt_q;
   assign start_o   = start_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_acorn128_input_loader.sv
// Testbench for acorn128_input_loader (WAIT_TIMEOUT = 8). Expected outputs come
// from a field-level model: the last completed job's key/IV/AD/text/length.
module tb_acorn128_input_loader;

   localparam int unsigned TMO = 8;
`ifdef ACORN_KEY_RETAIN_EN
   localparam bit RETAIN = 1'b1;
`else
   localparam bit RETAIN = 1'b0;
`endif

   localparam logic [127:0] V_KEY  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] V_IV   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] V_AD   = 128'h11223344556677889900AABBCCDDEEFF;
   localparam logic [127:0] V_TEXT = 128'hAABBCCDDEEFF00112233445566778899;
   localparam logic [63:0]  V_LEN  = 64'h0000000000000080;

   logic         clk;
   logic         rst;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         s_first;
   logic         s_encrypt;
   logic         s_keep_key;
   logic [127:0] key_o;
   logic [127:0] iv_o;
   logic [127:0] ad_o;
   logic [127:0] text_o;
   logic [63:0]  length_o;
   logic         encrypt_o;
   logic         start_o;
   logic         core_ready_i;
   logic         busy_o;
   logic         done_o;
   logic         err_o;

   int n_cmp   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int n_start = 0;
   int ns_job  = 0;

   logic [127:0] m_key, m_iv, m_ad, m_text;
   logic [63:0]  m_len;
   logic         m_enc;
   bit           m_kv;

   acorn128_input_loader #(.WAIT_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_first      (s_first),
      .s_encrypt    (s_encrypt),
      .s_keep_key   (s_keep_key),
      .key_o        (key_o),
      .iv_o         (iv_o),
      .ad_o         (ad_o),
      .text_o       (text_o),
      .length_o     (length_o),
      .encrypt_o    (encrypt_o),
      .start_o      (start_o),
      .core_ready_i (core_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start_o) n_start <= n_start + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_key"},  key_o,    m_key);
      chk({tag, "_iv"},   iv_o,     m_iv);
      chk({tag, "_ad"},   ad_o,     m_ad);
      chk({tag, "_text"}, text_o,   m_text);
      chk({tag, "_len"},  length_o, m_len);
      chk({tag, "_enc"},  encrypt_o, m_enc);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Offer one word starting at a negedge; returns at the negedge after it was taken.
   task automatic put(input logic [31:0] d, input logic f, input logic e, input logic k,
                      input bit gaps);
      int g;
      if (gaps) begin
         g = $urandom_range(0, 2);
         repeat (g) begin
            s_valid = 1'b0;
            @(negedge clk);
         end
      end
      s_valid    = 1'b1;
      s_data     = d;
      s_first    = f;
      s_encrypt  = e;
      s_keep_key = k;
      g = 0;
      while (!s_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("put_ready", s_ready, 1'b1);
      @(negedge clk);
   endtask

   // Sends a whole job, updates the model, and checks the START cycle.
   task automatic run_job(input logic [127:0] k, input logic [127:0] iv, input logic [127:0] ad,
                          input logic [127:0] tx, input logic [63:0] ln, input logic enc,
                          input logic keep, input bit gaps, input logic exp_err, input string tag);
      logic [31:0] w[$];
      bit skip;
      int t0;
      skip = RETAIN && keep && m_kv;
      if (!skip) for (int i = 0; i < 4; i++) w.push_back(k[127-32*i -: 32]);
      for (int i = 0; i < 4; i++) w.push_back(iv[127-32*i -: 32]);
      for (int i = 0; i < 4; i++) w.push_back(ad[127-32*i -: 32]);
      for (int i = 0; i < 4; i++) w.push_back(tx[127-32*i -: 32]);
      for (int i = 0; i < 2; i++) w.push_back(ln[63-32*i -: 32]);
      ns_job = n_start;
      t0 = 0;
      for (int i = 0; i < w.size(); i++) begin
         put(w[i], (i == 0), enc, keep, gaps);
         if (i == 0) begin
            t0 = cyc;
            chk({tag, "_first_err"}, err_o, exp_err);
         end
      end
      s_valid = 1'b0;
      s_first = 1'b0;
      if (!skip) m_key = k;
      m_iv  = iv;
      m_ad  = ad;
      m_text = tx;
      m_len = ln;
      m_enc = enc;
      m_kv  = 1'b1;
      if (!gaps) chk({tag, "_start_cycle"}, cyc + 1 - t0, w.size());
      chk({tag, "_start"}, start_o, 1'b1);
      chk({tag, "_ready_start"}, s_ready, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b1);
      chk_outputs(tag);
   endtask

   // From START: offer junk (must not be taken), then give the core-ready edge.
   task automatic finish_job(input bit gaps, input string tag);
      int d;
      s_valid = 1'b1;
      s_first = 1'b1;
      s_data  = $urandom;
      @(negedge clk);
      chk({tag, "_start_pulse"}, start_o, 1'b0);
      d = gaps ? $urandom_range(0, 3) : 1;
      repeat (d) begin
         chk({tag, "_ready_wait"}, s_ready, 1'b0);
         @(negedge clk);
      end
      chk({tag, "_ready_wait"}, s_ready, 1'b0);
      s_valid = 1'b0;
      s_first = 1'b0;
      core_ready_i = 1'b1;
      @(negedge clk);
      chk({tag, "_done"}, done_o, 1'b1);
      chk({tag, "_busy_done"}, busy_o, 1'b0);
      chk({tag, "_err_done"}, err_o, 1'b0);
      core_ready_i = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done_o, 1'b0);
      chk({tag, "_idle_ready"}, s_ready, 1'b1);
      chk({tag, "_one_start"}, n_start - ns_job, 1);
      chk_outputs({tag, "_held"});
   endtask

   initial begin
      int k;
      int ns0;
      logic [127:0] ka, kb;
      rst = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_first = 1'b0;
      s_encrypt = 1'b0;
      s_keep_key = 1'b0;
      core_ready_i = 1'b0;
      m_key = '0; m_iv = '0; m_ad = '0; m_text = '0; m_len = '0; m_enc = 1'b0; m_kv = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk_outputs("rst");
      chk("rst_ready", s_ready, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_start", start_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", s_ready, 1'b1);

      // 1. Full load, back-to-back
      run_job(V_KEY, V_IV, V_AD, V_TEXT, V_LEN, 1'b1, 1'b0, 1'b0, 1'b0, "t1");
      finish_job(1'b0, "t1");

      // 2. Backpressure and gaps: same data, then random jobs
      run_job(V_KEY, V_IV, V_AD, V_TEXT, V_LEN, 1'b1, 1'b0, 1'b1, 1'b0, "t2a");
      finish_job(1'b1, "t2a");
      for (int j = 0; j < 3; j++) begin
         run_job(rnd128(), rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, "t2r");
         finish_job(1'b1, "t2r");
      end

      // 3a. Non-first word in IDLE
      put(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
      s_valid = 1'b0;
      chk("t3a_err", err_o, 1'b1);
      chk("t3a_busy", busy_o, 1'b0);
      chk("t3a_ready", s_ready, 1'b1);
      @(negedge clk);
      chk("t3a_err_pulse", err_o, 1'b0);
      chk_outputs("t3a");

      // 3b. s_first at IV word2 restarts the job
      put($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) put($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3b_busy_partial", busy_o, 1'b1);
      run_job(rnd128(), rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
              1'b0, 1'b0, 1'b0, 1'b1, "t3b");
      finish_job(1'b0, "t3b");

      // 4a. Stale-high ready is ignored, done only on the rising edge
      core_ready_i = 1'b1;
      run_job(rnd128(), rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
              1'b1, 1'b0, 1'b0, 1'b0, "t4");
      @(negedge clk);
      chk("t4_stale0", done_o, 1'b0);
      core_ready_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t4_stale_nodone", done_o, 1'b0);
         chk("t4_stale_busy", busy_o, 1'b1);
      end
      core_ready_i = 1'b1;
      @(negedge clk);
      chk("t4_edge_done", done_o, 1'b1);
      chk("t4_edge_busy", busy_o, 1'b0);
      core_ready_i = 1'b0;
      @(negedge clk);
      chk_outputs("t4");

      // 4b. Timeout with no edge
      run_job(rnd128(), rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
              1'b0, 1'b0, 1'b0, 1'b0, "t4t");
      k = 0;
      while (!err_o && k < 20) begin
         @(negedge clk);
         k++;
         if (!err_o) chk("t4t_no_done", done_o, 1'b0);
      end
      chk("t4t_wait_cycles", k - 1, TMO);
      chk("t4t_busy", busy_o, 1'b0);
      chk("t4t_ready", s_ready, 1'b1);
      chk("t4t_done", done_o, 1'b0);
      chk_outputs("t4t");

      // 4c. Edge in the timeout cycle: done wins
      run_job(rnd128(), rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
              1'b1, 1'b0, 1'b0, 1'b0, "t4e");
      repeat (TMO) @(negedge clk);
      chk("t4e_busy_last", busy_o, 1'b1);
      core_ready_i = 1'b1;
      @(negedge clk);
      chk("t4e_done", done_o, 1'b1);
      chk("t4e_err", err_o, 1'b0);
      core_ready_i = 1'b0;
      @(negedge clk);
      chk("t4e_err_late", err_o, 1'b0);

      // 5. Reset mid-job, then a job with keep_key but no valid key
      ns0 = n_start;
      put(V_KEY[127:96], 1'b1, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 9; j++) put($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      s_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      m_key = '0; m_iv = '0; m_ad = '0; m_text = '0; m_len = '0; m_enc = 1'b0; m_kv = 1'b0;
      chk_outputs("t5_rst");
      chk("t5_ready", s_ready, 1'b0);
      chk("t5_busy", busy_o, 1'b0);
      chk("t5_start", start_o, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_no_start", n_start - ns0, 0);
      chk("t5_idle_ready", s_ready, 1'b1);
      run_job(V_KEY, V_IV, V_AD, V_TEXT, V_LEN, 1'b1, 1'b1, 1'b0, 1'b0, "t5");
      finish_job(1'b0, "t5");

      // 6. Key retain: second job asks to keep the key
      ka = rnd128();
      kb = rnd128();
      run_job(ka, rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
              1'b1, 1'b0, 1'b0, 1'b0, "t6a");
      finish_job(1'b0, "t6a");
      run_job(kb, rnd128(), rnd128(), rnd128(), {$urandom, $urandom},
              1'b0, 1'b1, 1'b0, 1'b0, "t6b");
      finish_job(1'b0, "t6b");
      chk("t6_key", key_o, RETAIN ? ka : kb);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
